// File: rtl/memory_access.sv
// RV32I memory stage: EX/MEM pipeline register plus word-organised data memory.
// Define MISALIGN_CHECK_EN to flag misaligned half/word accesses and suppress their side effects.
module memory_access #(
    parameter int unsigned DMEM_DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] i_ALU_output_E,
    input  logic [31:0] i_wr_data_E,
    input  logic [4:0]  i_register_file_wr_addr_E,
    input  logic        i_register_file_wr_en_E,
    input  logic        i_sel_result_E,
    input  logic        i_mem_wr_en_E,
    input  logic [2:0]  i_funct3_E,
    input  logic        i_stall_M,
    input  logic        i_flush_M,
    output logic [31:0] o_ALU_output_M,
    output logic [31:0] o_rd_data_M,
    output logic [4:0]  o_register_file_wr_addr_M,
    output logic        o_register_file_wr_en_M,
    output logic        o_sel_result_M,
    output logic        o_misaligned_M
);

    localparam int unsigned AW = $clog2(DMEM_DEPTH);

    logic [31:0] alu_q, alu_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic [4:0]  rd_addr_q, rd_addr_d;
    logic        rf_wr_en_q, rf_wr_en_d;
    logic        sel_result_q, sel_result_d;
    logic        mem_wr_en_q, mem_wr_en_d;
    logic [2:0]  funct3_q, funct3_d;

    always_comb begin
        alu_d        = alu_q;
        wr_data_d    = wr_data_q;
        rd_addr_d    = rd_addr_q;
        rf_wr_en_d   = rf_wr_en_q;
        sel_result_d = sel_result_q;
        mem_wr_en_d  = mem_wr_en_q;
        funct3_d     = funct3_q;
        if (i_flush_M) begin
            alu_d        = '0;
            wr_data_d    = '0;
            rd_addr_d    = '0;
            rf_wr_en_d   = 1'b0;
            sel_result_d = 1'b0;
            mem_wr_en_d  = 1'b0;
            funct3_d     = '0;
        end else if (!i_stall_M) begin
            alu_d        = i_ALU_output_E;
            wr_data_d    = i_wr_data_E;
            rd_addr_d    = i_register_file_wr_addr_E;
            rf_wr_en_d   = i_register_file_wr_en_E;
            sel_result_d = i_sel_result_E;
            mem_wr_en_d  = i_mem_wr_en_E;
            funct3_d     = i_funct3_E;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_q        <= '0;
            wr_data_q    <= '0;
            rd_addr_q    <= '0;
            rf_wr_en_q   <= 1'b0;
            sel_result_q <= 1'b0;
            mem_wr_en_q  <= 1'b0;
            funct3_q     <= '0;
        end else begin
            alu_q        <= alu_d;
            wr_data_q    <= wr_data_d;
            rd_addr_q    <= rd_addr_d;
            rf_wr_en_q   <= rf_wr_en_d;
            sel_result_q <= sel_result_d;
            mem_wr_en_q  <= mem_wr_en_d;
            funct3_q     <= funct3_d;
        end
    end

    logic [31:0] mem [DMEM_DEPTH];
    logic [AW-1:0] word_idx;
    logic [1:0]    offset;
    logic          misaligned;

    assign word_idx = alu_q[AW+1:2];
    assign offset   = alu_q[1:0];

`ifdef MISALIGN_CHECK_EN
    logic access_byte, access_half;

    // Stores decode size from the full funct3; loads ignore the sign bit.
    always_comb begin
        if (mem_wr_en_q) begin
            access_byte = (funct3_q == 3'b000);
            access_half = (funct3_q == 3'b001);
        end else begin
            access_byte = (funct3_q[1:0] == 2'b00);
            access_half = (funct3_q[1:0] == 2'b01);
        end
    end

    assign misaligned = (mem_wr_en_q | sel_result_q) &
                        ((access_half & offset[0]) |
                         (!access_byte & !access_half & (offset != 2'b00)));
`else
    assign misaligned = 1'b0;
`endif

    logic [3:0]  wr_be;
    logic [31:0] wr_lanes;
    logic        mem_we;

    always_comb begin
        wr_be    = '0;
        wr_lanes = '0;
        case (funct3_q)
            3'b000: begin
                wr_be    = 4'b0001 << offset;
                wr_lanes = {4{wr_data_q[7:0]}};
            end
            3'b001: begin
                wr_be    = offset[1] ? 4'b1100 : 4'b0011;
                wr_lanes = {2{wr_data_q[15:0]}};
            end
            default: begin
                wr_be    = 4'b1111;
                wr_lanes = wr_data_q;
            end
        endcase
    end

    assign mem_we = mem_wr_en_q & ~misaligned;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (wr_be[i]) begin
                    mem[word_idx][8*i +: 8] <= wr_lanes[8*i +: 8];
                end
            end
        end
    end

    logic [31:0] rd_word;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    always_comb begin
        rd_word = mem[word_idx];
        rd_half = offset[1] ? rd_word[31:16] : rd_word[15:0];
        case (offset)
            2'd0:    rd_byte = rd_word[7:0];
            2'd1:    rd_byte = rd_word[15:8];
            2'd2:    rd_byte = rd_word[23:16];
            default: rd_byte = rd_word[31:24];
        endcase
        case (funct3_q)
            3'b000:  o_rd_data_M = {{24{rd_byte[7]}}, rd_byte};
            3'b100:  o_rd_data_M = {24'd0, rd_byte};
            3'b001:  o_rd_data_M = {{16{rd_half[15]}}, rd_half};
            3'b101:  o_rd_data_M = {16'd0, rd_half};
            default: o_rd_data_M = rd_word;
        endcase
    end

    assign o_ALU_output_M            = alu_q;
    assign o_register_file_wr_addr_M = rd_addr_q;
    assign o_register_file_wr_en_M   = rf_wr_en_q & ~misaligned;
    assign o_sel_result_M            = sel_result_q;
    assign o_misaligned_M            = misaligned;

endmodule
